// File: rtl/sign_extension_pkg.sv
// Shared RV32I decode definitions: instruction/opcode widths, opcode
// encodings and the immediate-format enum used by the decoder and the
// immediate generator.
`ifndef SIGN_EXTENSION_DEFINES
`define SIGN_EXTENSION_DEFINES

`define INST_WIDTH 32
`define OPCODE     7

`define OP_LUI    7'b0110111
`define OP_AUIPC  7'b0010111
`define OP_JAL    7'b1101111
`define OP_JALR   7'b1100111
`define OP_BRANCH 7'b1100011
`define OP_LOAD   7'b0000011
`define OP_STORE  7'b0100011
`define OP_ALUI   7'b0010011
`define OP_ALU    7'b0110011

`endif

package sign_extension_pkg;

    // Immediate layout selected by the opcode; FMT_NONE means no immediate.
    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/sign_extension_imm_format_decode.sv
// Opcode to immediate-format decoder. Purely combinational.
module imm_format_decode
    import sign_extension_pkg::*;
(
    input  logic [`OPCODE-1:0] opcode,
    output imm_fmt_e           imm_fmt
);

    // Map each immediate-bearing opcode to its format; everything else is NONE.
    always_comb begin
        imm_fmt = FMT_NONE;
        case (opcode)
            `OP_ALUI, `OP_LOAD, `OP_JALR: imm_fmt = FMT_I;
            `OP_STORE:                    imm_fmt = FMT_S;
            `OP_BRANCH:                   imm_fmt = FMT_B;
            `OP_LUI, `OP_AUIPC:           imm_fmt = FMT_U;
            `OP_JAL:                      imm_fmt = FMT_J;
            default:                      imm_fmt = FMT_NONE;
        endcase
    end

endmodule

// File: rtl/sign_extension.sv
// RV32I immediate generator. The combinational immediate feeds same-cycle
// consumers (ALU B-mux, target adders); a registered copy plus a valid flag
// serves the pipelined execute stage. i_inst[6:0] is not used: the format
// comes from the decoded opcode only.
module sign_extension
    import sign_extension_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [`INST_WIDTH-1:0] i_inst,
    input  logic [`OPCODE-1:0]     i_opcode,
    output logic [`INST_WIDTH-1:0] o_immediate_extended,
    output logic [`INST_WIDTH-1:0] o_immediate_q,
    output logic                   o_imm_valid_q
);

    imm_fmt_e imm_fmt;
    logic     sign_bit;
    logic     imm_valid;

    imm_format_decode u_imm_format_decode (
        .opcode  (i_opcode),
        .imm_fmt (imm_fmt)
    );

    assign sign_bit  = i_inst[31];
    assign imm_valid = (imm_fmt != FMT_NONE);

    // Assemble and sign-extend the immediate for the selected format.
    // Shift-immediates get the full I-immediate; the ALU only uses [4:0].
    always_comb begin
        o_immediate_extended = '0;
        case (imm_fmt)
            FMT_I: o_immediate_extended = {{20{sign_bit}}, i_inst[31:20]};
            FMT_S: o_immediate_extended = {{20{sign_bit}}, i_inst[31:25], i_inst[11:7]};
            FMT_B: o_immediate_extended = {{19{sign_bit}}, i_inst[31], i_inst[7],
                                           i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U: o_immediate_extended = {i_inst[31:12], 12'b0};
            FMT_J: o_immediate_extended = {{11{sign_bit}}, i_inst[31], i_inst[19:12],
                                           i_inst[20], i_inst[30:21], 1'b0};
            default: o_immediate_extended = '0;
        endcase
    end

    // Capture the immediate and its valid flag every cycle; reset clears both at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_immediate_q <= '0;
            o_imm_valid_q <= 1'b0;
        end else begin
            o_immediate_q <= o_immediate_extended;
            o_imm_valid_q <= imm_valid;
        end
    end

endmodule

// File: tb/tb_sign_extension.sv
// Directed bench for the RV32I immediate generator: combinational result,
// registered copy, valid flag and asynchronous reset behaviour.
module tb_sign_extension;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] imm_comb;
    logic [31:0] imm_q;
    logic        valid_q;

    int checks;
    int errors;

    sign_extension dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_inst               (inst),
        .i_opcode             (opcode),
        .o_immediate_extended (imm_comb),
        .o_immediate_q        (imm_q),
        .o_imm_valid_q        (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        vld;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        inst   = 32'h0;
        opcode = `OP_ALU;

        vecs.push_back('{`OP_ALUI,   32'h80000000, 32'hfffff800, 1'b1, "alui_neg"});
        vecs.push_back('{`OP_LOAD,   32'h10100000, 32'h00000101, 1'b1, "load_pos"});
        vecs.push_back('{`OP_STORE,  32'h80F80023, 32'hfffff800, 1'b1, "store_neg"});
        vecs.push_back('{`OP_STORE,  32'h00F80023, 32'h00000000, 1'b1, "store_zero"});
        vecs.push_back('{`OP_LUI,    32'h000170b7, 32'h00017000, 1'b1, "lui"});
        vecs.push_back('{`OP_AUIPC,  32'h000170b7, 32'h00017000, 1'b1, "auipc"});
        vecs.push_back('{`OP_JALR,   32'h00c00167, 32'h0000000c, 1'b1, "jalr"});
        vecs.push_back('{`OP_JAL,    32'h0e80026f, 32'h000000e8, 1'b1, "jal_pos"});
        vecs.push_back('{`OP_JAL,    32'hf19ff26f, 32'hffffff18, 1'b1, "jal_neg"});
        vecs.push_back('{`OP_BRANCH, 32'hfe4104e3, 32'hffffffe8, 1'b1, "branch_neg"});
        vecs.push_back('{`OP_ALU,    32'hffffffff, 32'h00000000, 1'b0, "alu_none"});
        vecs.push_back('{7'b1110011, 32'hfff00073, 32'h00000000, 1'b0, "system_none"});
        vecs.push_back('{`OP_ALUI,   32'h7ff00093, 32'h000007ff, 1'b1, "alui_max"});

        // Reset state
        #12;
        check("rst_imm_q", imm_q, 32'h0);
        check("rst_valid_q", {31'b0, valid_q}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Each vector: combinational now, registered after the next rising edge
        foreach (vecs[i]) begin
            @(negedge clk);
            inst   = vecs[i].ins;
            opcode = vecs[i].op;
            #1;
            check({vecs[i].name, "_comb"}, imm_comb, vecs[i].imm);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q"}, imm_q, vecs[i].imm);
            check({vecs[i].name, "_valid"}, {31'b0, valid_q}, {31'b0, vecs[i].vld});
        end

        // Back-to-back stream: q lags the combinational path by one cycle
        @(negedge clk);
        inst = 32'hfe4104e3; opcode = `OP_BRANCH;
        @(posedge clk); #1;
        inst = 32'h000170b7; opcode = `OP_LUI;
        #1;
        check("stream_q_prev", imm_q, 32'hffffffe8);
        check("stream_comb_new", imm_comb, 32'h00017000);
        @(posedge clk); #1;
        check("stream_q_next", imm_q, 32'h00017000);

        // Asynchronous reset between edges
        @(negedge clk);
        inst = 32'hf19ff26f; opcode = `OP_JAL;
        @(posedge clk); #2;
        check("pre_rst_q", imm_q, 32'hffffff18);
        rst_n = 1'b0;
        #1;
        check("async_rst_q", imm_q, 32'h0);
        check("async_rst_valid", {31'b0, valid_q}, 32'h0);
        check("async_rst_comb", imm_comb, 32'hffffff18);
        @(posedge clk); #1;
        check("held_rst_q", imm_q, 32'h0);

        // Release; first edge loads normally
        @(negedge clk);
        rst_n = 1'b1;
        inst = 32'h00c00167; opcode = `OP_JALR;
        @(posedge clk); #1;
        check("post_rst_q", imm_q, 32'h0000000c);
        check("post_rst_valid", {31'b0, valid_q}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
